// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM state and requester-id types shared by the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, IF_RESP, LS_RESP} state_e;
  typedef enum logic {REQ_IF, REQ_LS} req_id_e;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch, load/store and unified memory bus signals of mem_arbiter
interface mem_arb_if #(parameter int WIDTH = 32);
  logic if_req;
  logic [WIDTH-1:0] if_addr;
  logic if_gnt;
  logic if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  logic ls_req;
  logic ls_we;
  logic [WIDTH-1:0] ls_addr;
  logic [WIDTH-1:0] ls_wdata;
  logic [3:0] ls_byteen;
  logic ls_gnt;
  logic ls_rvalid;
  logic [WIDTH-1:0] ls_rdata;
  logic mem_read;
  logic mem_write;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0] mem_byteen;
  logic [WIDTH-1:0] mem_rdata;
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_byteen, mem_rdata,
    input if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
  );
  modport slave (
    input if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_byteen, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
  );
endinterface

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: picks the winning requester; load/store wins unless fetch is starved
module mem_arb_prio
  import mem_arb_pkg::*;
(
  input  logic    if_req,
  input  logic    ls_req,
  input  logic    starve,
  output req_id_e winner
);
  always_comb winner = (if_req && (!ls_req || starve)) ? REQ_IF : REQ_LS;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between fetch and load/store; define ARB_STARVE_GUARD_EN to bound fetch starvation
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst,
  mem_arb_if.slave bus
);
  state_e state;
  req_id_e win;
  logic we_q;
  logic starve;
  logic idle;
  logic gnt_if;
  logic gnt_ls;
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || gnt_if || (gnt_ls && !bus.if_req)) cnt <= '0;
    else if (gnt_ls) cnt <= cnt + CW'(1);
  assign starve = cnt >= CW'(STARVE_LIMIT);
`else
  assign starve = 1'b0;
`endif
  mem_arb_prio u_prio (
    .if_req(bus.if_req),
    .ls_req(bus.ls_req),
    .starve(starve),
    .winner(win)
  );
  // grants are held off during reset so nothing is accepted that reset would drop
  always_comb begin
    idle = (state == IDLE) && !rst;
    gnt_if = idle && bus.if_req && (win == REQ_IF);
    gnt_ls = idle && bus.ls_req && (win == REQ_LS);
    bus.if_gnt = gnt_if;
    bus.ls_gnt = gnt_ls;
    bus.mem_read = gnt_if || (gnt_ls && !bus.ls_we);
    bus.mem_write = gnt_ls && bus.ls_we;
    bus.mem_addr = gnt_if ? bus.if_addr : gnt_ls ? bus.ls_addr : '0;
    bus.mem_wdata = gnt_ls ? bus.ls_wdata : '0;
    bus.mem_byteen = gnt_if ? 4'hF : gnt_ls ? bus.ls_byteen : 4'h0;
    bus.if_rvalid = (state == IF_RESP) && !rst;
    bus.ls_rvalid = (state == LS_RESP) && !rst;
    bus.if_rdata = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.ls_rdata = (bus.ls_rvalid && !we_q) ? bus.mem_rdata : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
    end else begin
      state <= gnt_if ? IF_RESP : gnt_ls ? LS_RESP : IDLE;
      if (gnt_ls) we_q <= bus.ls_we;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int W = 32;
  localparam int LIM = 4;
  localparam logic [31:0] DMEM_BEGIN = 32'h0000_1000;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic if_gnt;
    logic if_rvalid;
    logic [31:0] if_rdata;
    logic ls_gnt;
    logic ls_rvalid;
    logic [31:0] ls_rdata;
    logic mem_read;
    logic mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0] mem_byteen;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  int n_cmp;
  int n_bad;
  int streak;
  int dut_if;
  logic pend_if, pend_ls, g_if, g_ls;
  logic [31:0] pend_data;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  mem_arb_if #(.WIDTH(W)) bus ();
  mem_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] img(input int i);
    return (i == 4) ? 32'h0000_0013 : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) o[8*i +: 8] = d[8*i +: 8];
    return o;
  endfunction

  // bus-side memory: one-cycle read latency, byte-enabled writes, no address decoding
  always @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= img(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
      if (bus.mem_write) mem[bus.mem_addr[7:2]] <= merge(mem[bus.mem_addr[7:2]], bus.mem_wdata, bus.mem_byteen);
    end

  function automatic obs_t observe();
    return '{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.ls_gnt, bus.ls_rvalid, bus.ls_rdata,
             bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata, bus.mem_byteen};
  endfunction

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 64; i++) ref_mem[i] = img(i);
    pend_if = 1'b0;
    pend_ls = 1'b0;
    g_if = 1'b0;
    g_ls = 1'b0;
    streak = 0;
  endtask

  task automatic clear_in();
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.ls_req = 1'b0;
    bus.ls_we = 1'b0;
    bus.ls_addr = '0;
    bus.ls_wdata = '0;
    bus.ls_byteen = 4'h0;
  endtask

  // transaction model: every grant is followed by exactly one response cycle
  task automatic step(input string tag);
    obs_t e;
    e = '0;
    g_if = 1'b0;
    g_ls = 1'b0;
    if (pend_if || pend_ls) begin
      e.if_rvalid = pend_if;
      e.if_rdata = pend_if ? pend_data : 32'h0;
      e.ls_rvalid = pend_ls;
      e.ls_rdata = pend_ls ? pend_data : 32'h0;
      pend_if = 1'b0;
      pend_ls = 1'b0;
    end else begin
      g_if = bus.if_req && (!bus.ls_req || (GUARD && streak >= LIM));
      g_ls = bus.ls_req && !g_if;
      if (g_if) begin
        e.if_gnt = 1'b1;
        e.mem_read = 1'b1;
        e.mem_addr = bus.if_addr;
        e.mem_byteen = 4'hF;
        pend_if = 1'b1;
        pend_data = ref_mem[bus.if_addr[7:2]];
        streak = 0;
      end
      if (g_ls) begin
        e.ls_gnt = 1'b1;
        e.mem_read = !bus.ls_we;
        e.mem_write = bus.ls_we;
        e.mem_addr = bus.ls_addr;
        e.mem_wdata = bus.ls_wdata;
        e.mem_byteen = bus.ls_byteen;
        pend_ls = 1'b1;
        pend_data = bus.ls_we ? 32'h0 : ref_mem[bus.ls_addr[7:2]];
        if (bus.ls_we) ref_mem[bus.ls_addr[7:2]] = merge(ref_mem[bus.ls_addr[7:2]], bus.ls_wdata, bus.ls_byteen);
        streak = bus.if_req ? streak + 1 : 0;
      end
    end
    chk(tag, observe(), e);
  endtask

  function automatic logic [31:0] raddr();
    return {4'($urandom_range(0, 15)), 20'h0, 6'($urandom_range(0, 63)), 2'b00};
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    dut_if = 0;
    clear_in();
    reset_model();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("in_reset", observe(), '0);
    rst = 1'b0;

    @(negedge clk);
    #1 chk("idle_after_reset", observe(), '0);

    @(negedge clk);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0010;
    #1 step("fetch_gnt");
    chk("fetch_gnt_pin", bus.if_gnt, 1'b1);
    @(negedge clk);
    bus.if_req = 1'b0;
    #1 step("fetch_resp");
    chk("fetch_rdata", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h0000_0013});

    @(negedge clk);
    bus.ls_req = 1'b1;
    bus.ls_we = 1'b1;
    bus.ls_addr = DMEM_BEGIN;
    bus.ls_wdata = 32'hDEAD_BEEF;
    bus.ls_byteen = 4'hF;
    #1 step("store_gnt");
    chk("store_bus", {bus.mem_write, bus.mem_read, bus.mem_wdata}, {2'b10, 32'hDEAD_BEEF});
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1 step("store_resp");
    chk("store_rdata", {bus.ls_rvalid, bus.ls_rdata, bus.mem_write}, {1'b1, 32'h0, 1'b0});
    @(negedge clk);
    bus.ls_req = 1'b1;
    bus.ls_we = 1'b0;
    #1 step("load_gnt");
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1 step("load_resp");
    chk("load_rdata", bus.ls_rdata, 32'hDEAD_BEEF);

    @(negedge clk);
    bus.ls_req = 1'b1;
    bus.ls_we = 1'b1;
    bus.ls_addr = DMEM_BEGIN + 32'h4;
    bus.ls_wdata = 32'h1122_3344;
    bus.ls_byteen = 4'b0011;
    #1 step("pstore_gnt");
    chk("pstore_bus", {bus.mem_byteen, bus.mem_read, bus.mem_write}, {4'b0011, 2'b01});
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1 step("pstore_resp");
    @(negedge clk);
    bus.ls_req = 1'b1;
    bus.ls_we = 1'b0;
    bus.ls_byteen = 4'hF;
    #1 step("pload_gnt");
    @(negedge clk);
    bus.ls_req = 1'b0;
    #1 step("pload_resp");
    chk("pload_rdata", bus.ls_rdata, 32'h0000_3344);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.if_req = 1'b1;
      bus.if_addr = 32'h0000_0010;
      bus.ls_req = 1'b1;
      bus.ls_we = 1'b0;
      bus.ls_addr = DMEM_BEGIN;
      #1 step("simul");
      if (bus.if_gnt) dut_if++;
    end
    chk("simul_if_grants", dut_if, GUARD ? 2 : 0);

    @(negedge clk);
    clear_in();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0000_0010;
    #1 step("rst_fetch_gnt");
    @(negedge clk);
    rst = 1'b1;
    bus.if_req = 1'b0;
    #1 chk("rst_no_rvalid", {bus.if_rvalid, bus.if_rdata}, '0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_idle_outs", observe(), '0);
    @(negedge clk);
    bus.if_req = 1'b1;
    #1 step("post_rst_gnt");
    @(negedge clk);
    bus.if_req = 1'b0;
    #1 step("post_rst_resp");

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (g_if) bus.if_req = 1'b0;
      if (g_ls) bus.ls_req = 1'b0;
      if (!bus.if_req && $urandom_range(0, 1) == 1) begin
        bus.if_req = 1'b1;
        bus.if_addr = raddr();
      end
      if (!bus.ls_req && $urandom_range(0, 1) == 1) begin
        bus.ls_req = 1'b1;
        bus.ls_we = 1'($urandom_range(0, 1));
        bus.ls_addr = raddr();
        bus.ls_wdata = $urandom;
        bus.ls_byteen = 4'($urandom_range(0, 15));
      end
      #1 step("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001: Parameter WIDTH, default 32: address and data width.
- REQ-002: Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while fetch waits.
- REQ-003: clk  in  1: single clock; all state updates on the rising edge.
- REQ-004: rst  in  1: synchronous, active-high reset.
- REQ-005: if_req  in  1: instruction-fetch read request; held with if_addr stable until granted.
- REQ-006: if_addr  in  WIDTH: fetch byte address.
- REQ-007: if_gnt  out  1: fetch request accepted this cycle.
- REQ-008: if_rvalid  out  1: one-cycle pulse; if_rdata valid.
- REQ-009: if_rdata  out  WIDTH: fetched instruction word.
- REQ-010: ls_req  in  1: load/store request; held with ls_we, ls_addr, ls_wdata and ls_byteen stable until granted.
- REQ-011: ls_we  in  1: 1 = store, 0 = load.
- REQ-012: ls_addr  in  WIDTH; ls_wdata  in  WIDTH; ls_byteen  in  4: load/store address, store data and byte enables.
- REQ-013: ls_gnt  out  1: load/store request accepted this cycle.
- REQ-014: ls_rvalid  out  1: one-cycle completion pulse for loads and stores.
- REQ-015: ls_rdata  out  WIDTH: load data; 0 on store completion.
- REQ-016: mem_read, mem_write  out  1 each: bus controls to the unified memory bus.
- REQ-017: mem_addr, mem_wdata  out  WIDTH; mem_byteen  out  4: bus address, write data and byte enables.
- REQ-018: mem_rdata  in  WIDTH: bus read data, valid one cycle after mem_read is asserted.

Function
- REQ-019: The FSM SHALL have three states: IDLE, IF_RESP and LS_RESP.
- REQ-020: In IDLE, at most one of if_gnt and ls_gnt SHALL assert; the grant and bus controls are combinational from the requests in the same cycle.
- REQ-021: Granted fetch SHALL drive mem_read=1, mem_addr=if_addr, mem_byteen=4'hF, and then go to IF_RESP.
- REQ-022: Granted load/store SHALL drive mem_read=!ls_we, mem_write=ls_we, ls_addr, ls_wdata and ls_byteen, and then go to LS_RESP.
- REQ-023: IF_RESP and LS_RESP SHALL last exactly one cycle:
  - assert the matching rvalid;
  - rdata = mem_rdata (ls_rdata = 0 for a store);
  - no grant is issued and the bus is idle;
  - next state is IDLE.
- REQ-024: Latency SHALL be grant in cycle N and rvalid in cycle N+1; maximum throughput is one transaction per 2 cycles.
- REQ-025: Priority on simultaneous if_req and ls_req SHALL go to ls, subject to REQ-031.
- REQ-026: When bus controls are not driven, mem_read, mem_write, mem_addr, mem_wdata and mem_byteen SHALL be 0.
- REQ-027: Outside their response cycle, if_rdata and ls_rdata SHALL be 0.
- REQ-028: The arbiter SHALL NOT decode or range-check addresses; decoding belongs to the memory bus.

Reset
- REQ-029: When rst=1, the next state SHALL be IDLE, the starvation counter SHALL clear, and all outputs SHALL be 0 in the following cycle.
- REQ-030: Reset in IF_RESP or LS_RESP SHALL drop the outstanding response (no rvalid); the requester re-issues.

Configuration
- REQ-031: With ARB_STARVE_GUARD_EN defined:
  - a counter SHALL increment on each ls grant while if_req=1;
  - the counter SHALL clear on any if grant, or when if_req=0 at an ls grant;
  - when the counter reaches STARVE_LIMIT, if wins the next simultaneous request.
- REQ-032: Without ARB_STARVE_GUARD_EN, strict ls priority SHALL apply and no counter SHALL be instantiated.

Structure
- REQ-033: Package mem_arb_pkg SHALL hold the state enum (IDLE, IF_RESP, LS_RESP) and the requester-id enum (REQ_IF, REQ_LS).
- REQ-034: Sub-module mem_arb_prio SHALL be the combinational winner select: requests and starve flag in, requester id out.

Verification
- REQ-035: The bench SHALL cover these directed scenarios:
  - Fetch alone: if_req, if_addr=0x0000_0010, memory returns 0x0000_0013 -> if_gnt in cycle N, if_rvalid with if_rdata=0x13 in N+1.
  - Store then load: store ls_addr=DMEM_BEGIN, wdata=0xDEADBEEF, byteen=4'hF -> mem_write pulse, ls_rvalid with ls_rdata=0; then load same address -> ls_rdata=0xDEADBEEF.
  - Simultaneous requests, guard off -> ls granted every IDLE cycle; if_gnt never asserts while ls_req is held.
  - Simultaneous requests, guard on, STARVE_LIMIT=4 -> four ls grants, then one if grant, then the pattern repeats.
  - rst asserted in IF_RESP -> no if_rvalid; IDLE and all outputs 0 on the next cycle.
  - Partial store with byteen=4'b0011 -> mem_byteen=4'b0011 and mem_read=0 during the grant cycle.
